// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with sticky
// illegal-opcode and memory time-out traps plus a retired-instruction counter.
module multicycle_controller #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 imem_ready,
  output logic                 imem_req,
  input  logic                 dmem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 alu_zero,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [3:0]           alu_control,
  output logic                 alu_src_b,
  output logic                 wb_sel,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic                 illegal,
  output logic                 bus_error,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam int WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);

  state_t         cur, nxt;
  logic [31:0]    ir;
  logic [WW-1:0]  wait_cnt;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       r_legal, br_legal, legal, timeout, taken;
  logic [3:0] arith_op;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

  assign is_r  = (opcode == 7'b0110011);
  assign is_i  = (opcode == 7'b0010011);
  assign is_ld = (opcode == 7'b0000011);
  assign is_st = (opcode == 7'b0100011);
  assign is_br = (opcode == 7'b1100011);

  assign r_legal = ((funct7 == 7'b0000000) &&
                    (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110 ||
                     funct3 == 3'b100 || funct3 == 3'b010)) ||
                   ((funct7 == 7'b0100000) && (funct3 == 3'b000));
  assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign legal    = (is_r && r_legal) || is_i || is_ld || is_st || (is_br && br_legal);

  // funct3 == 001 is bne; everything else reaching EXECUTE as a branch is beq
  assign taken = funct3[0] ? !alu_zero : alu_zero;

  // Last permitted waiting cycle: a miss here traps, a hit here still succeeds
  assign timeout = (wait_cnt == WW'(WAIT_LIMIT - 1));

  always_comb begin
    arith_op = 4'b0000;
    case (funct3)
      3'b000:  arith_op = (is_r && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  arith_op = ALU_AND;
      3'b110:  arith_op = ALU_OR;
      3'b100:  arith_op = ALU_XOR;
      3'b010:  arith_op = ALU_SLT;
      default: arith_op = 4'b0000;
    endcase
  end

  always_comb begin
    nxt         = cur;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    alu_control = 4'b0000;
    alu_src_b   = 1'b0;
    wb_sel      = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          nxt      = S_DECODE;
        end else if (timeout) begin
          nxt = S_TRAP;
        end
      end
      S_DECODE: nxt = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (is_r || is_i) begin
          alu_control = arith_op;
          alu_src_b   = is_i;
          nxt         = S_WRITEBACK;
        end else if (is_ld || is_st) begin
          alu_control = ALU_ADD;
          alu_src_b   = 1'b1;
          nxt         = S_MEM;
        end else if (is_br) begin
          alu_control = ALU_SUB;
          pc_write    = 1'b1;
          pc_src      = taken;
          nxt         = S_FETCH;
        end else begin
          nxt = S_TRAP;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ready) begin
          if (is_st) begin
            pc_write = 1'b1;
            nxt      = S_FETCH;
          end else begin
            nxt = S_WRITEBACK;
          end
        end else if (timeout) begin
          nxt = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        reg_write = (rd != 5'd0);
        wb_sel    = is_ld;
        pc_write  = 1'b1;
        nxt       = S_FETCH;
      end
      default: nxt = S_TRAP;
    endcase
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= S_FETCH;
      ir           <= 32'd0;
      wait_cnt     <= '0;
      retire_count <= '0;
      illegal      <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && imem_ready)
        ir <= instr;
      if (nxt != cur)
        wait_cnt <= '0;
      else if (cur == S_FETCH || cur == S_MEM)
        wait_cnt <= wait_cnt + 1'b1;
      if (pc_write)
        retire_count <= retire_count + 1'b1;
      if (cur == S_DECODE && nxt == S_TRAP)
        illegal <= 1'b1;
      if ((cur == S_FETCH || cur == S_MEM) && nxt == S_TRAP)
        bus_error <= 1'b1;
    end
  end

  assign state = cur;

endmodule
